// File: rtl/wlan_ilv_pkg.sv
// rtl/wlan_ilv_pkg.sv - shared types and per-rate constants for the 802.11a interleaver controller
// Contents: rate codes, FSM state encoding, NCBPS / (NCBPS/16) / s tables and lookup functions.
package wlan_ilv_pkg;

  typedef enum logic [1:0] {
    RATE_BPSK  = 2'b00,
    RATE_QPSK  = 2'b01,
    RATE_16QAM = 2'b10,
    RATE_64QAM = 2'b11
  } rate_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    PAD    = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  localparam int NCBPS_BPSK  = 48;
  localparam int NCBPS_QPSK  = 96;
  localparam int NCBPS_16QAM = 192;
  localparam int NCBPS_64QAM = 288;

  localparam int NROW_BPSK  = 3;
  localparam int NROW_QPSK  = 6;
  localparam int NROW_16QAM = 12;
  localparam int NROW_64QAM = 18;

  localparam int S_BPSK  = 1;
  localparam int S_QPSK  = 1;
  localparam int S_16QAM = 2;
  localparam int S_64QAM = 3;

  function automatic int ncbps(rate_e r);
    case (r)
      RATE_BPSK:  return NCBPS_BPSK;
      RATE_QPSK:  return NCBPS_QPSK;
      RATE_16QAM: return NCBPS_16QAM;
      default:    return NCBPS_64QAM;
    endcase
  endfunction

  // Rows of the 16-column write matrix, i.e. NCBPS/16.
  function automatic int nrows(rate_e r);
    case (r)
      RATE_BPSK:  return NROW_BPSK;
      RATE_QPSK:  return NROW_QPSK;
      RATE_16QAM: return NROW_16QAM;
      default:    return NROW_64QAM;
    endcase
  endfunction

endpackage

// File: rtl/interleaver_ctrl_if.sv
// rtl/interleaver_ctrl_if.sv - coded-bit input and RAM sequencing bus of the interleaver controller
// master: drives frame_start/rate/in_valid/frame_end, observes RAM strobes and status.
// slave : the controller. sym_count exists only when SYM_CNT_EN is defined.
interface interleaver_ctrl_if #(
  parameter int AW = 9,
  parameter int CW = 16
);
  logic          frame_start;
  logic [1:0]    rate;
  logic          in_valid;
  logic          frame_end;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          wr_zero;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          busy;
  logic          err;
`ifdef SYM_CNT_EN
  logic [CW-1:0] sym_count;
`endif

  modport master (
    output frame_start, rate, in_valid, frame_end,
    input  wr_en, wr_bank, wr_addr, wr_zero, rd_en, rd_bank, rd_addr, out_valid, busy, err
`ifdef SYM_CNT_EN
    , input sym_count
`endif
  );

  modport slave (
    input  frame_start, rate, in_valid, frame_end,
    output wr_en, wr_bank, wr_addr, wr_zero, rd_en, rd_bank, rd_addr, out_valid, busy, err
`ifdef SYM_CNT_EN
    , output sym_count
`endif
  );
endinterface

// File: rtl/ilv_addr_gen.sv
// rtl/ilv_addr_gen.sv - combinational 802.11a two-step permutation of write index k
// Ports: rate_i (latched rate), col_i = k mod 16, row_i = k / 16, j_o = permuted RAM index.
module ilv_addr_gen
  import wlan_ilv_pkg::*;
#(
  parameter int AW = 9
) (
  input  rate_e         rate_i,
  input  logic [3:0]    col_i,
  input  logic [4:0]    row_i,
  output logic [AW-1:0] j_o
);

  logic [AW:0] n_w;
  logic [AW:0] nrow_w;
  logic [AW:0] col_w;
  logic [AW:0] i_w;
  logic [AW:0] t_w;
  logic [AW:0] i_mod;
  logic [AW:0] t_mod;

  always_comb begin
    n_w    = (AW+1)'(ncbps(rate_i));
    nrow_w = (AW+1)'(nrows(rate_i));
    col_w  = {{(AW-3){1'b0}}, col_i};
    // First permutation: i = (N/16)*col + row.
    i_w    = nrow_w * col_w + {{(AW-4){1'b0}}, row_i};
    // i >= col always (N/16 >= 3), so i + N - col never underflows.
    t_w    = i_w + n_w - col_w;
    // s is 1, 2 or 3: the remainders are a wire, a bit, or a constant-3 modulo.
    case (rate_i)
      RATE_16QAM: begin
        i_mod = {{AW{1'b0}}, i_w[0]};
        t_mod = {{AW{1'b0}}, t_w[0]};
      end
      RATE_64QAM: begin
        i_mod = i_w % (AW+1)'(3);
        t_mod = t_w % (AW+1)'(3);
      end
      default: begin
        i_mod = '0;
        t_mod = '0;
      end
    endcase
    // Second permutation: j = s*floor(i/s) + (i + N - col) mod s.
    j_o = AW'(i_w - i_mod + t_mod);
  end

endmodule

// File: rtl/interleaver_ctrl.sv
// rtl/interleaver_ctrl.sv - ping-pong bank sequencer for the 802.11a bit interleaver RAM
// Ports: clk, reset (async active-low), bus (interleaver_ctrl_if.slave: coded-bit input
// qualifiers in, RAM write/read strobes, addresses, banks, out_valid, busy, err out).
// Optional: define SYM_CNT_EN to add the saturating sym_count of completed read passes.
module interleaver_ctrl
  import wlan_ilv_pkg::*;
#(
  parameter int AW = 9,
  parameter int CW = 16
) (
  input  logic clk,
  input  logic reset,
  interleaver_ctrl_if.slave bus
);

  state_e        state_q, state_d;
  rate_e         rate_q, rate_d;
  logic [3:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic          bank_q, bank_d;
  logic          rd_act_q, rd_act_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          out_valid_q;
  logic          err_q, err_d;

  logic [AW-1:0] n_m1;
  logic [4:0]    last_row;
  logic          sym_last;
  logic          wr_fire;
  logic          sym_done;
  logic          rd_last;
  logic [AW-1:0] j_w;

  ilv_addr_gen #(.AW(AW)) u_addr_gen (
    .rate_i (rate_q),
    .col_i  (col_q),
    .row_i  (row_q),
    .j_o    (j_w)
  );

  always_comb begin
    n_m1     = AW'(ncbps(rate_q) - 1);
    last_row = 5'(nrows(rate_q) - 1);
    sym_last = (col_q == 4'd15) && (row_q == last_row);
    wr_fire  = (((state_q == FILL) || (state_q == STREAM)) && bus.in_valid) || (state_q == PAD);
    sym_done = wr_fire && sym_last;
    rd_last  = rd_act_q && (rd_addr_q == n_m1);
  end

  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    col_d     = col_q;
    row_d     = row_q;
    bank_d    = bank_q;
    rd_act_d  = rd_act_q;
    rd_addr_d = rd_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d = FILL;
          rate_d  = rate_e'(bus.rate);
          col_d   = '0;
          row_d   = '0;
        end
      end
      FILL, STREAM: begin
        if (bus.in_valid) begin
          if (sym_last)           state_d = bus.frame_end ? DRAIN : STREAM;
          else if (bus.frame_end) state_d = PAD;
        end
      end
      PAD:     if (sym_last) state_d = DRAIN;
      DRAIN:   if (rd_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_fire) begin
      if (sym_last) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == 4'd15) begin
        col_d = '0;
        row_d = row_q + 5'd1;
      end else begin
        col_d = col_q + 4'd1;
      end
    end

    // A completed symbol swaps banks and (re)starts the read of the bank just filled;
    // the previous pass has always finished by then since a symbol takes >= N cycles.
    if (sym_done) begin
      bank_d    = ~bank_q;
      rd_act_d  = 1'b1;
      rd_addr_d = '0;
    end else if (rd_act_q) begin
      if (rd_last) rd_act_d  = 1'b0;
      else         rd_addr_d = rd_addr_q + AW'(1);
    end

    err_d = (bus.frame_start && (state_q != IDLE)) ||
            (bus.in_valid && (state_q == IDLE)) ||
            (bus.frame_end && !bus.in_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rate_q      <= RATE_BPSK;
      col_q       <= '0;
      row_q       <= '0;
      bank_q      <= 1'b0;
      rd_act_q    <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      col_q       <= col_d;
      row_q       <= row_d;
      bank_q      <= bank_d;
      rd_act_q    <= rd_act_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= rd_act_q;
      err_q       <= err_d;
    end
  end

`ifdef SYM_CNT_EN
  logic [CW-1:0] sym_cnt_q, sym_cnt_d;

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    if ((state_q == IDLE) && bus.frame_start)  sym_cnt_d = '0;
    else if (rd_last && (sym_cnt_q != '1))      sym_cnt_d = sym_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sym_cnt_q <= '0;
    else        sym_cnt_q <= sym_cnt_d;
  end

  assign bus.sym_count = sym_cnt_q;
`endif

  assign bus.wr_en     = wr_fire;
  assign bus.wr_bank   = bank_q;
  assign bus.wr_addr   = j_w;
  assign bus.wr_zero   = (state_q == PAD);
  assign bus.rd_en     = rd_act_q;
  // The read side always targets the bank opposite the current write bank.
  assign bus.rd_bank   = rd_act_q & ~bank_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_interleaver_ctrl.sv
// tb/tb_interleaver_ctrl.sv - directed self-checking bench for interleaver_ctrl
module tb_interleaver_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interleaver_ctrl_if #(.AW(9), .CW(16)) ilv ();

  interleaver_ctrl #(.AW(9), .CW(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ilv.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int got_addr [0:287];
  bit seen [0:511];
  int exp_rd;
  int exp_rd_bank;
  int rd_total;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ncb(input int r);
    case (r)
      0:       return 48;
      1:       return 96;
      2:       return 192;
      default: return 288;
    endcase
  endfunction

  function automatic int ref_j(input int r, input int k);
    int n, s, col, row, i;
    n = ncb(r);
    s = (r == 3) ? 3 : ((r == 2) ? 2 : 1);
    col = k % 16;
    row = k / 16;
    i = (n / 16) * col + row;
    return s * (i / s) + ((i + n - col) % s);
  endfunction

  task automatic step(input bit fs, input bit v, input bit fe);
    @(negedge clk);
    ilv.frame_start = fs;
    ilv.in_valid    = v;
    ilv.frame_end   = fe;
    #1;
  endtask

  task automatic zero_check(input string p);
    check({p, "_wr_en"},     ilv.wr_en,     0);
    check({p, "_wr_bank"},   ilv.wr_bank,   0);
    check({p, "_wr_addr"},   ilv.wr_addr,   0);
    check({p, "_wr_zero"},   ilv.wr_zero,   0);
    check({p, "_rd_en"},     ilv.rd_en,     0);
    check({p, "_rd_bank"},   ilv.rd_bank,   0);
    check({p, "_rd_addr"},   ilv.rd_addr,   0);
    check({p, "_out_valid"}, ilv.out_valid, 0);
    check({p, "_busy"},      ilv.busy,      0);
    check({p, "_err"},       ilv.err,       0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ilv.frame_start = 1'b0;
    ilv.in_valid    = 1'b0;
    ilv.frame_end   = 1'b0;
    #1;
    zero_check("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycles following the final write of a frame: N gap-free reads, then idle.
  task automatic drain_check(input int n, input int bank);
    for (int a = 0; a < n; a++) begin
      step(0, 0, 0);
      check("rd_en",     ilv.rd_en,     1);
      check("rd_addr",   ilv.rd_addr,   a);
      check("rd_bank",   ilv.rd_bank,   bank);
      check("out_valid", ilv.out_valid, (a > 0) ? 1 : 0);
    end
    step(0, 0, 0);
    check("drain_rd_off",  ilv.rd_en,     0);
    check("drain_ov_tail", ilv.out_valid, 1);
    check("drain_busy",    ilv.busy,      0);
  endtask

  task automatic perm_frame(input int r, input bit rst);
    int n;
    if (rst) do_reset();
    n = ncb(r);
    for (int x = 0; x < 512; x++) seen[x] = 1'b0;
    ilv.rate = 2'(r);
    step(1, 0, 0);
    for (int k = 0; k < n; k++) begin
      step(0, 1, k == n - 1);
      check("wr_en",    ilv.wr_en,   1);
      check("wr_addr",  ilv.wr_addr, ref_j(r, k));
      check("wr_bank",  ilv.wr_bank, 0);
      check("perm_dup", seen[ilv.wr_addr], 0);
      seen[ilv.wr_addr] = 1'b1;
      got_addr[k] = ilv.wr_addr;
      if (k == n - 1) check("no_early_rd", ilv.rd_en, 0);
    end
    drain_check(n, 0);
  endtask

  task automatic rd_model(input bit done, input int bank);
    check("rd_en_model", ilv.rd_en, (exp_rd >= 0) ? 1 : 0);
    if (exp_rd >= 0) begin
      check("rd_addr_model", ilv.rd_addr, exp_rd);
      check("rd_bank_model", ilv.rd_bank, exp_rd_bank);
      rd_total++;
    end
    if (done) begin
      exp_rd      = 0;
      exp_rd_bank = bank;
    end else if (exp_rd >= 0) begin
      exp_rd = (exp_rd == 47) ? -1 : exp_rd + 1;
    end
  endtask

  task automatic gapped_bpsk();
    int to;
    bit v;
    do_reset();
    ilv.rate = 2'b00;
    step(1, 0, 0);
    exp_rd   = -1;
    rd_total = 0;
    for (int b = 0; b < 144; b++) begin
      for (int g = 0; g < 3; g++) begin
        v = (g == 0);
        step(0, v, v && (b == 143));
        if (v) begin
          check("gap_wr_en",   ilv.wr_en,   1);
          check("gap_wr_bank", ilv.wr_bank, (b / 48) % 2);
          check("gap_wr_addr", ilv.wr_addr, ref_j(0, b % 48));
        end else begin
          check("gap_no_wr", ilv.wr_en, 0);
        end
        rd_model(v && (b % 48 == 47), (b / 48) % 2);
      end
    end
    to = 0;
    while (ilv.busy && to < 200) begin
      step(0, 0, 0);
      rd_model(0, 0);
      to++;
    end
    check("bpsk_drain_done", ilv.busy, 0);
    check("bpsk_rd_total",   rd_total, 144);
  endtask

  task automatic pad_frame();
    do_reset();
    ilv.rate = 2'b01;
    step(1, 0, 0);
    step(0, 0, 1);
    for (int k = 0; k <= 40; k++) begin
      step(0, 1, k == 40);
      if (k == 0) begin
        check("fe_novalid_err", ilv.err,  1);
        check("fe_novalid_fill", ilv.busy, 1);
      end
      check("pre_pad_zero", ilv.wr_zero, 0);
      check("pre_pad_addr", ilv.wr_addr, ref_j(1, k));
    end
    for (int k = 41; k <= 95; k++) begin
      step(0, k % 2, 0);
      check("pad_wr_en",   ilv.wr_en,   1);
      check("pad_wr_zero", ilv.wr_zero, 1);
      check("pad_wr_addr", ilv.wr_addr, ref_j(1, k));
    end
    drain_check(96, 0);
    check("post_pad_zero", ilv.wr_zero, 0);
  endtask

  task automatic err_and_abort();
    do_reset();
    step(0, 1, 0);
    check("idle_no_wr", ilv.wr_en, 0);
    step(0, 0, 0);
    check("idle_err",  ilv.err,  1);
    check("idle_busy", ilv.busy, 0);
    ilv.rate = 2'b01;
    step(1, 0, 0);
    for (int k = 0; k < 96; k++) step(0, 1, 0);
    ilv.rate = 2'b11;
    step(1, 1, 0);
    step(0, 1, 0);
    check("busy_fs_err", ilv.err,     1);
    check("rate_kept",   ilv.wr_addr, 6);
    step(0, 1, 0);
    check("err_one_cycle", ilv.err,     0);
    check("rate_kept2",    ilv.wr_addr, 12);
    for (int k = 3; k <= 50; k++) step(0, 1, 0);
    check("pre_rst_rd_en",   ilv.rd_en,   1);
    check("pre_rst_rd_addr", ilv.rd_addr, 50);
    rst_n = 1'b0;
    #1;
    zero_check("arst");
    @(negedge clk);
    rst_n = 1'b1;
    ilv.in_valid = 1'b0;
    perm_frame(2, 0);
    check("post_rst_16qam_k1", got_addr[1], 13);
  endtask

  initial begin
    ilv.frame_start = 1'b0;
    ilv.in_valid    = 1'b0;
    ilv.frame_end   = 1'b0;
    ilv.rate        = 2'b00;

    perm_frame(1, 1);
    check("qpsk_k0",  got_addr[0],  0);
    check("qpsk_k1",  got_addr[1],  6);
    check("qpsk_k16", got_addr[16], 1);
    check("qpsk_k95", got_addr[95], 95);
    perm_frame(2, 1);
    check("16qam_k1", got_addr[1], 13);
    perm_frame(3, 1);
    check("64qam_k1", got_addr[1], 20);
    check("64qam_k2", got_addr[2], 37);
    perm_frame(0, 1);

    gapped_bpsk();
    pad_frame();
    err_and_abort();

`ifdef SYM_CNT_EN
    begin
      int to;
      do_reset();
      ilv.rate = 2'b11;
      step(1, 0, 0);
      for (int k = 0; k < 1152; k++) step(0, 1, k == 1151);
      to = 0;
      while (ilv.busy && to < 400) begin
        step(0, 0, 0);
        to++;
      end
      check("sc_busy_end", ilv.busy,      0);
      check("sym_count_4", ilv.sym_count, 4);
      step(1, 0, 0);
      step(0, 0, 0);
      check("sym_count_clr", ilv.sym_count, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/interleaver_ctrl.md
Name: interleaver_ctrl

Overview:
- Sequencing controller for the 802.11a bit interleaver datapath, a dual-bank (ping-pong) 1-bit-wide RAM of 2x288 entries.
- Counts coded bits per OFDM symbol and generates the permuted write address (802.11a two-step permutation) and linear read address.
- Swaps banks on symbol boundaries, pads short final symbols, and drains the last bank at frame end.
- Sits between the convolutional encoder/puncturer output and the mapper; the RAM and data mux are outside this block.

Parameters:
- AW, 9, RAM address width per bank (holds max index 287).
- CW, 16, width of optional symbol counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse: begin frame; rate sampled this cycle.
- rate  in  2  00 BPSK (NCBPS 48, s=1); 01 QPSK (96, s=1); 10 16QAM (192, s=2); 11 64QAM (288, s=3).
- in_valid  in  1  coded bit present this cycle.
- frame_end  in  1  qualifies in_valid: this bit is the last of the frame.
- wr_en  out  1  write strobe to RAM.
- wr_bank  out  1  bank written.
- wr_addr  out  AW  permuted index j.
- wr_zero  out  1  datapath writes 0 instead of input bit (padding).
- rd_en  out  1  read strobe.
- rd_bank  out  1  bank read.
- rd_addr  out  AW  linear index.
- out_valid  out  1  rd_en delayed one cycle; RAM synchronous read data is valid.
- busy  out  1  high in any state except IDLE.
- err  out  1  one-cycle pulse on protocol error.
- sym_count  out  CW  present only with SYM_CNT_EN.

Behaviour:
- Reset: every output is 0; state IDLE; bank pointer 0; counters 0.
- Rate is latched on frame_start in IDLE. Rate changes are ignored mid-frame.
- Write index: k counts 0..N-1; col = k mod 16; row = k/16. Both are kept as counters, with no divider.
  - i = (N/16)*col + row.
  - j = s*floor(i/s) + (i + N - col) mod s.
  - Intermediates use AW+1 bits; j < N always.
- wr_en = in_valid while in FILL or STREAM, or every cycle in PAD. wr_addr/wr_bank are combinational from the registered counters, so the address is valid in the same cycle as in_valid.
- IDLE -> FILL on frame_start.
- FILL: write only.
  - Write of k=N-1: swap banks, go to STREAM, start the read on the next cycle.
  - frame_end with k<N-1 goes to PAD.
- STREAM: write and read run concurrently.
  - Read issues rd_addr 0..N-1 on consecutive cycles with no gaps, from the bank just completed.
  - Read always finishes before the next write completes, because writing needs at least N cycles.
  - On write completion: swap, restart read.
- PAD: wr_zero=1 and wr_en=1 each cycle until k=N-1; then swap and go to DRAIN. in_valid is ignored in PAD and DRAIN.
- frame_end on k=N-1 (exact symbol boundary): swap and go directly to DRAIN.
- DRAIN: finish reading the final bank (rd_addr reaches N-1), then return to IDLE. busy falls the cycle after the last rd_en.
- Latency: the first rd_en comes one cycle after the N-th write; out_valid comes one cycle after that.
- Errors (each pulses err; none change state):
  - frame_start while busy is ignored.
  - in_valid in IDLE is ignored (no write).
  - frame_end without in_valid is ignored.
- Asynchronous reset mid-frame aborts immediately: all outputs 0; partial RAM contents are abandoned.
- Bank pointer toggles on every swap and wraps naturally, 1 -> 0.

Optional Feature:
- SYM_CNT_EN defined:
  - sym_count port exists.
  - Clears on frame_start; increments on each completed read pass (rd_addr = N-1).
  - Saturates at 2^CW-1 and holds its value in IDLE.
- Undefined: no port, no logic.

Decomposition:
- Package wlan_ilv_pkg holds:
  - rate codes RATE_BPSK/QPSK/16QAM/64QAM.
  - NCBPS constants 48/96/192/288 and N/16 constants 3/6/12/18.
  - s values 1/1/2/3.
  - state encoding IDLE, FILL, STREAM, PAD, DRAIN.
- One sub-module, ilv_addr_gen: combinational j from (rate, col, row).

Test Plan:
- QPSK, 96 contiguous bits:
  - k=0,1,16,95 -> wr_addr 0,6,1,95.
  - rd_en first asserted one cycle after the 96th write.
  - rd_addr 0..95 on bank 0.
  - busy falls after drain.
- 16QAM: k=1 -> wr_addr 13; 64QAM: k=1 -> 20, k=2 -> 37. Check the full 0..N-1 sequence against a reference model for all 4 rates: each a permutation, no duplicate j.
- BPSK, 3 symbols with in_valid gapped 1-of-3 -> writes stall, reads stay gap-free, wr_bank alternates 0,1,0, final DRAIN completes.
- QPSK frame_end at k=40 of first symbol -> PAD with wr_zero=1 for k=41..95 (55 cycles); then swap, DRAIN of 96 reads, IDLE.
- frame_start mid-STREAM -> err pulse for 1 cycle, rate unchanged. Then assert reset at k=50 -> all outputs 0 the same cycle; a new frame after reset is correct.
- SYM_CNT_EN, 64QAM, 4 symbols -> sym_count=4 after DRAIN; clears to 0 on the next frame_start.
